hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 16-bit five-stage core; it is the producer of the `stall` input of the IF/ID pipeline register. It detects load-use hazards between ID and EX, freezes the whole pipeline during multi-cycle data-memory accesses, and squashes wrong-path instructions on taken branches. It generates the IF/ID hold, the ID/EX bubble, the freeze signal and synchronous flushes, so flushes never travel on the global reset.

---
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 16-bit five-stage core.
// Detects ID/EX load-use hazards, freezes the pipeline during multi-cycle
// data-memory accesses and flushes wrong-path instructions on taken branches.
// All control outputs are combinational from the FSM state and the inputs.
// Optional statistics counters are built when HAZARD_STATS_EN is defined;
// otherwise the statistics ports are tied to zero.
module hazard_ctrl #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  src1_ID,
    input  logic [3:0]  src2_ID,
    input  logic        src1_vld_ID,
    input  logic        src2_vld_ID,
    input  logic [3:0]  rd_EX,
    input  logic        mem_rd_EX,
    input  logic        branch_taken_EX,
    input  logic        mem_req_MEM,
    output logic        stall_IF_ID,
    output logic        bubble_ID_EX,
    output logic        freeze,
    output logic        flush_IF_ID,
    output logic        flush_ID_EX,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic [15:0] freeze_cycles
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // MEM_LAT==1 never freezes; MEM_LAT==2 freezes one cycle and skips WAIT.
    localparam logic       LAT_GT1  = (MEM_LAT > 1);
    localparam logic       LAT_GT2  = (MEM_LAT > 2);
    localparam logic       LAT_EQ2  = (MEM_LAT == 2);
    localparam logic [3:0] CNT_INIT = LAT_GT2 ? 4'(MEM_LAT - 3) : 4'd0;

    state_t     r_state;
    logic [3:0] r_cnt;

    logic w_freeze;
    logic w_load_use;
    logic w_active;
    logic w_flush;
    logic w_stall;

    // Memory-access FSM: RUN -> (WAIT x MEM_LAT-2) -> RELEASE -> RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (mem_req_MEM && LAT_GT2) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CNT_INIT;
                    end else if (mem_req_MEM && LAT_EQ2) begin
                        r_state <= S_RELEASE;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RELEASE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                // The request still visible here is the same access leaving MEM.
                S_RELEASE: r_state <= S_RUN;
                default:   r_state <= S_RUN;
            endcase
        end
    end

    // Hazard detection and output priority: freeze > taken branch > load-use.
    always_comb begin
        w_freeze   = rst_n & (((r_state == S_RUN) & mem_req_MEM & LAT_GT1)
                              | (r_state == S_WAIT));
        w_load_use = mem_rd_EX & (rd_EX != 4'd0)
                     & ((src1_vld_ID & (src1_ID == rd_EX))
                        | (src2_vld_ID & (src2_ID == rd_EX)));
        w_active   = rst_n & ~w_freeze;
        // A wrong-path load-use behind a taken branch is discarded.
        w_flush    = w_active & branch_taken_EX;
        w_stall    = w_active & ~branch_taken_EX & w_load_use;
    end

    assign freeze       = w_freeze;
    assign flush_IF_ID  = w_flush;
    assign flush_ID_EX  = w_flush;
    assign stall_IF_ID  = w_stall;
    assign bubble_ID_EX = w_stall;

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_count;
    logic [15:0] r_freeze_cycles;

    // Saturating event counters; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles  <= 16'h0000;
            r_flush_count   <= 16'h0000;
            r_freeze_cycles <= 16'h0000;
        end else begin
            if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (w_flush && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
            if (w_freeze && (r_freeze_cycles != 16'hFFFF)) begin
                r_freeze_cycles <= r_freeze_cycles + 16'd1;
            end
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign flush_count   = r_flush_count;
    assign freeze_cycles = r_freeze_cycles;
`else
    assign stall_cycles  = 16'h0000;
    assign flush_count   = 16'h0000;
    assign freeze_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Five instances with MEM_LAT = 1, 2, 3,
// 4 and 8 share the same stimulus; each check looks at the relevant instance.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] src1_ID, src2_ID, rd_EX;
    logic       src1_vld_ID, src2_vld_ID, mem_rd_EX, branch_taken_EX, mem_req_MEM;

    logic        stall [5];
    logic        bubble [5];
    logic        frz [5];
    logic        fl_if [5];
    logic        fl_ex [5];
    logic [15:0] st_c [5];
    logic [15:0] fl_c [5];
    logic [15:0] fr_c [5];

    int checks = 0;
    int errors = 0;

    // index 0..4 -> MEM_LAT 1,2,3,4,8
    localparam int L1 = 0, L2 = 1, L3 = 2, L4 = 3, L8 = 4;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_LAT(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .src1_ID(src1_ID), .src2_ID(src2_ID),
        .src1_vld_ID(src1_vld_ID), .src2_vld_ID(src2_vld_ID), .rd_EX(rd_EX),
        .mem_rd_EX(mem_rd_EX), .branch_taken_EX(branch_taken_EX), .mem_req_MEM(mem_req_MEM),
        .stall_IF_ID(stall[0]), .bubble_ID_EX(bubble[0]), .freeze(frz[0]),
        .flush_IF_ID(fl_if[0]), .flush_ID_EX(fl_ex[0]),
        .stall_cycles(st_c[0]), .flush_count(fl_c[0]), .freeze_cycles(fr_c[0]));
    hazard_ctrl #(.MEM_LAT(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .src1_ID(src1_ID), .src2_ID(src2_ID),
        .src1_vld_ID(src1_vld_ID), .src2_vld_ID(src2_vld_ID), .rd_EX(rd_EX),
        .mem_rd_EX(mem_rd_EX), .branch_taken_EX(branch_taken_EX), .mem_req_MEM(mem_req_MEM),
        .stall_IF_ID(stall[1]), .bubble_ID_EX(bubble[1]), .freeze(frz[1]),
        .flush_IF_ID(fl_if[1]), .flush_ID_EX(fl_ex[1]),
        .stall_cycles(st_c[1]), .flush_count(fl_c[1]), .freeze_cycles(fr_c[1]));
    hazard_ctrl #(.MEM_LAT(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .src1_ID(src1_ID), .src2_ID(src2_ID),
        .src1_vld_ID(src1_vld_ID), .src2_vld_ID(src2_vld_ID), .rd_EX(rd_EX),
        .mem_rd_EX(mem_rd_EX), .branch_taken_EX(branch_taken_EX), .mem_req_MEM(mem_req_MEM),
        .stall_IF_ID(stall[2]), .bubble_ID_EX(bubble[2]), .freeze(frz[2]),
        .flush_IF_ID(fl_if[2]), .flush_ID_EX(fl_ex[2]),
        .stall_cycles(st_c[2]), .flush_count(fl_c[2]), .freeze_cycles(fr_c[2]));
    hazard_ctrl #(.MEM_LAT(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .src1_ID(src1_ID), .src2_ID(src2_ID),
        .src1_vld_ID(src1_vld_ID), .src2_vld_ID(src2_vld_ID), .rd_EX(rd_EX),
        .mem_rd_EX(mem_rd_EX), .branch_taken_EX(branch_taken_EX), .mem_req_MEM(mem_req_MEM),
        .stall_IF_ID(stall[3]), .bubble_ID_EX(bubble[3]), .freeze(frz[3]),
        .flush_IF_ID(fl_if[3]), .flush_ID_EX(fl_ex[3]),
        .stall_cycles(st_c[3]), .flush_count(fl_c[3]), .freeze_cycles(fr_c[3]));
    hazard_ctrl #(.MEM_LAT(8)) u_l8 (
        .clk(clk), .rst_n(rst_n), .src1_ID(src1_ID), .src2_ID(src2_ID),
        .src1_vld_ID(src1_vld_ID), .src2_vld_ID(src2_vld_ID), .rd_EX(rd_EX),
        .mem_rd_EX(mem_rd_EX), .branch_taken_EX(branch_taken_EX), .mem_req_MEM(mem_req_MEM),
        .stall_IF_ID(stall[4]), .bubble_ID_EX(bubble[4]), .freeze(frz[4]),
        .flush_IF_ID(fl_if[4]), .flush_ID_EX(fl_ex[4]),
        .stall_cycles(st_c[4]), .flush_count(fl_c[4]), .freeze_cycles(fr_c[4]));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        src1_ID = 4'd0; src2_ID = 4'd0; rd_EX = 4'd0;
        src1_vld_ID = 1'b0; src2_vld_ID = 1'b0; mem_rd_EX = 1'b0;
        branch_taken_EX = 1'b0; mem_req_MEM = 1'b0;
    endtask

    task automatic set_load_use();
        mem_rd_EX = 1'b1; rd_EX = 4'd3; src2_ID = 4'd3; src2_vld_ID = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // Reset: controls held low even with every trigger asserted.
        idle_inputs();
        rst_n = 1'b0;
        set_load_use();
        branch_taken_EX = 1'b1;
        mem_req_MEM = 1'b1;
        #1;
        chk("rst_stall", {15'd0, stall[L2]}, 16'd0);
        chk("rst_freeze", {15'd0, frz[L2]}, 16'd0);
        chk("rst_flush", {15'd0, fl_if[L2]}, 16'd0);
        chk("rst_stall_cycles", st_c[L2], 16'h0000);
        chk("rst_freeze_cycles", fr_c[L4], 16'h0000);
        do_reset();

        // Load-use: one-cycle stall on src2 match.
        set_load_use();
        #1;
        chk("lu_stall", {15'd0, stall[L2]}, 16'd1);
        chk("lu_bubble", {15'd0, bubble[L2]}, 16'd1);
        chk("lu_no_flush", {15'd0, fl_ex[L2]}, 16'd0);
        tick();
        idle_inputs();
        #1;
        chk("lu_next_cycle", {15'd0, stall[L2]}, 16'd0);
        // rd_EX = R0 never stalls.
        set_load_use(); rd_EX = 4'd0; src2_ID = 4'd0;
        #1;
        chk("lu_r0", {15'd0, stall[L2]}, 16'd0);
        tick();
        // Source not read -> no stall.
        set_load_use(); src2_vld_ID = 1'b0;
        #1;
        chk("lu_src2_invalid", {15'd0, bubble[L2]}, 16'd0);
        tick();
        // src1 match with src2 mismatch.
        idle_inputs();
        mem_rd_EX = 1'b1; rd_EX = 4'd9; src1_ID = 4'd9; src1_vld_ID = 1'b1; src2_ID = 4'd4; src2_vld_ID = 1'b1;
        #1;
        chk("lu_src1", {15'd0, stall[L2]}, 16'd1);
        tick();
        // Not a load -> no stall.
        mem_rd_EX = 1'b0;
        #1;
        chk("lu_not_load", {15'd0, stall[L2]}, 16'd0);
        tick();
        do_reset();

        // Freeze length: request held 4 cycles.
        mem_req_MEM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("frz4_c%0d", i), {15'd0, frz[L4]}, (i < 3) ? 16'd1 : 16'd0);
            chk($sformatf("frz1_c%0d", i), {15'd0, frz[L1]}, 16'd0);
            // MEM_LAT=2: freeze, release, back-to-back freeze, release.
            chk($sformatf("frz2_c%0d", i), {15'd0, frz[L2]}, (i % 2 == 0) ? 16'd1 : 16'd0);
            tick();
        end
        mem_req_MEM = 1'b0;
        #1;
        chk("frz4_after", {15'd0, frz[L4]}, 16'd0);
        do_reset();

        // Branch together with load-use: flush wins, stall suppressed.
        set_load_use();
        branch_taken_EX = 1'b1;
        #1;
        chk("br_flush_if", {15'd0, fl_if[L2]}, 16'd1);
        chk("br_flush_ex", {15'd0, fl_ex[L2]}, 16'd1);
        chk("br_stall", {15'd0, stall[L2]}, 16'd0);
        chk("br_bubble", {15'd0, bubble[L2]}, 16'd0);
        tick();
        do_reset();

        // Branch during a MEM_LAT=3 access: freeze 2 cycles, flush in 3rd.
        mem_req_MEM = 1'b1;
        branch_taken_EX = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("brmem_frz_c%0d", i), {15'd0, frz[L3]}, (i < 2) ? 16'd1 : 16'd0);
            chk($sformatf("brmem_flush_c%0d", i), {15'd0, fl_if[L3]}, (i == 2) ? 16'd1 : 16'd0);
            chk($sformatf("brmem_flushex_c%0d", i), {15'd0, fl_ex[L3]}, (i == 2) ? 16'd1 : 16'd0);
            tick();
        end
        do_reset();

        // Reset in cycle 2 of a MEM_LAT=8 freeze, then a full new freeze.
        mem_req_MEM = 1'b1;
        #1;
        chk("rw_c1", {15'd0, frz[L8]}, 16'd1);
        tick();
        chk("rw_c2", {15'd0, frz[L8]}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_async_drop", {15'd0, frz[L8]}, 16'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("rw_new_c%0d", i), {15'd0, frz[L8]}, (i < 7) ? 16'd1 : 16'd0);
            tick();
        end
        do_reset();

`ifdef HAZARD_STATS_EN
        // Saturation after 70000 load-use cycles; freeze/flush counters untouched.
        set_load_use();
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        chk("stat_stall_sat", st_c[L2], 16'hFFFF);
        chk("stat_flush_idle", fl_c[L2], 16'h0000);
        chk("stat_freeze_idle", fr_c[L2], 16'h0000);
        do_reset();
        chk("stat_rst_stall", st_c[L2], 16'h0000);
        // Small exact counts: 3 freeze cycles at MEM_LAT=4, 1 flush.
        mem_req_MEM = 1'b1;
        branch_taken_EX = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        idle_inputs();
        tick();
        chk("stat_freeze_cnt", fr_c[L4], 16'd3);
        chk("stat_flush_cnt", fl_c[L4], 16'd1);
`else
        // Statistics ports tied off when counters are not built.
        set_load_use();
        tick();
        tick();
        chk("stat_off_stall", st_c[L2], 16'h0000);
        chk("stat_off_flush", fl_c[L2], 16'h0000);
        chk("stat_off_freeze", fr_c[L2], 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
